// File: rtl/job_seq_pkg.sv
// Shared types and default sizing for the job sequencer and its job FIFO.
package job_seq_pkg;

    localparam int DEFAULT_ENTRY_W        = 4;
    localparam int DEFAULT_RESULT_W       = 8;
    localparam int DEFAULT_FIFO_DEPTH     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUTPUT
    } state_t;

endpackage

// File: rtl/job_fifo.sv
// Synchronous FIFO holding pending job entries; pushes when full and pops when
// empty are dropped, and pointers wrap naturally because DEPTH is a power of two.
module job_fifo
    import job_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ENTRY_W,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/job_sequencer.sv
// Host-side initiator for the stack compute unit: buffers jobs, runs them one at a
// time and returns tagged results. Define JOB_SEQ_TIMEOUT_EN to build the WAIT watchdog.
module job_sequencer
    import job_seq_pkg::*;
#(
    parameter int ENTRY_W        = DEFAULT_ENTRY_W,
    parameter int RESULT_W       = DEFAULT_RESULT_W,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [ENTRY_W-1:0]  req_entry,
    output logic                req_ready,
    output logic                core_start,
    output logic [ENTRY_W-1:0]  core_entry,
    input  logic                core_done,
    input  logic [RESULT_W-1:0] core_result,
    output logic                res_valid,
    output logic [ENTRY_W-1:0]  res_entry,
    output logic [RESULT_W-1:0] res_data,
    output logic                res_timeout,
    input  logic                res_ready,
    output logic                busy
);

    state_t                      state;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic [ENTRY_W-1:0]          fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

    job_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (req_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign busy      = (state != IDLE);

    // The head is consumed on the same edge that moves the FSM into ISSUE.
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == OUTPUT) && res_ready));

`ifdef JOB_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          timeout_q;

    assign res_timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign res_timeout        = 1'b0;
`endif

    // core_start and core_entry are loaded on the transition into ISSUE so the
    // pulse and its operand appear together during the ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            core_start <= 1'b0;
            core_entry <= '0;
            res_valid  <= 1'b0;
            res_entry  <= '0;
            res_data   <= '0;
`ifdef JOB_SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state      <= ISSUE;
                        core_start <= 1'b1;
                        core_entry <= fifo_head;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef JOB_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    // A real done beats a watchdog expiry in the same cycle.
                    if (core_done) begin
                        state     <= OUTPUT;
                        res_valid <= 1'b1;
                        res_entry <= core_entry;
                        res_data  <= core_result;
`ifdef JOB_SEQ_TIMEOUT_EN
                        timeout_q <= 1'b0;
                    end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= OUTPUT;
                        res_valid <= 1'b1;
                        res_entry <= core_entry;
                        res_data  <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (!fifo_empty) begin
                            state      <= ISSUE;
                            core_start <= 1'b1;
                            core_entry <= fifo_head;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_job_sequencer.sv
// Self-checking bench for job_sequencer with a behavioural compute-unit model and a
// result scoreboard; the watchdog scenario runs only when JOB_SEQ_TIMEOUT_EN is defined.
module tb_job_sequencer;

    localparam int EW  = 4;
    localparam int RW  = 8;
    localparam int TMO = 16;

    typedef struct packed {
        logic [EW-1:0] entry;
        logic [RW-1:0] data;
        logic          tmo;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [EW-1:0] req_entry = '0;
    logic          req_ready;
    logic          core_start;
    logic [EW-1:0] core_entry;
    logic          core_done = 1'b0;
    logic [RW-1:0] core_result = '0;
    logic          res_valid;
    logic [EW-1:0] res_entry;
    logic [RW-1:0] res_data;
    logic          res_timeout;
    logic          res_ready = 1'b0;
    logic          busy;

    int   checks = 0;
    int   passed = 0;
    res_t sb[$];
    res_t obs_log [64];
    int   obs_n = 0;
    int   obs_rd = 0;
    int   starts = 0;
    int   overlap_errs = 0;
    logic core_hang = 1'b0;
    logic spurious_req = 1'b0;
    int   core_delay = 10;

    job_sequencer #(
        .ENTRY_W        (EW),
        .RESULT_W       (RW),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_entry   (req_entry),
        .req_ready   (req_ready),
        .core_start  (core_start),
        .core_entry  (core_entry),
        .core_done   (core_done),
        .core_result (core_result),
        .res_valid   (res_valid),
        .res_entry   (res_entry),
        .res_data    (res_data),
        .res_timeout (res_timeout),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] model_result(input logic [EW-1:0] e);
        return 8'(e * 3 + 2);
    endfunction

    // Compute-unit model: done fires core_delay cycles after the start cycle.
    bit            pending = 1'b0;
    int            cnt = 0;
    logic [EW-1:0] op = '0;
    always @(negedge clk) begin
        core_done = 1'b0;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                if (cnt <= 1) begin
                    core_done   = 1'b1;
                    core_result = model_result(op);
                    pending     = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (spurious_req) begin
                core_done   = 1'b1;
                core_result = 8'hAA;
            end
            if (core_start) begin
                starts++;
                if (pending) overlap_errs++;
                if (!core_hang) begin
                    pending = 1'b1;
                    cnt     = core_delay;
                    op      = core_entry;
                end
            end
        end
    end

    // Records every result handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (obs_n < 64) obs_log[obs_n] = {res_entry, res_data, res_timeout};
            obs_n++;
        end
    end

    task automatic push_job(input logic [EW-1:0] e, input logic tmo);
        for (int i = 0; i < 50 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        if (req_ready) begin
            req_valid = 1'b1;
            req_entry = e;
            sb.push_back({e, tmo ? 8'h00 : model_result(e), tmo});
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_obs(input int target, output bit ok);
        for (int i = 0; i < 600 && obs_n < target; i++) begin
            @(posedge clk); #1;
        end
        ok = (obs_n >= target);
    endtask

    task automatic wait_res_valid(output int n);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        logic [20:0] got;
        int          s0;
        #3;
        got = {req_ready, core_start, core_entry, res_valid, res_entry, res_data, res_timeout, busy};
        checks++;
        if (got !== {1'b1, 20'h0}) $display("[TB] FAIL reset_outputs: got %h expected %h", got, {1'b1, 20'h0});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        s0 = starts;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (starts !== s0) $display("[TB] FAIL reset_no_start: got %0d starts expected %0d", starts, s0);
        else passed++;
        checks++;
        if ({busy, req_ready} !== 2'b01) $display("[TB] FAIL reset_idle: got busy/ready %b expected 01", {busy, req_ready});
        else passed++;
    endtask

    task automatic test_single();
        int n;
        int m;
        bit ok;
        res_ready = 1'b1;
        req_valid = 1'b1;
        req_entry = 4'd6;
        sb.push_back({4'd6, model_result(4'd6), 1'b0});
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) req_valid = 1'b0;
            if (core_start) break;
        end
        checks++;
        if (n !== 2) $display("[TB] FAIL single_start_latency: got %0d cycles expected 2", n);
        else passed++;
        checks++;
        if (core_entry !== 4'd6) $display("[TB] FAIL single_core_entry: got %0d expected 6", core_entry);
        else passed++;
        m = 0;
        while (!res_valid && m < 50) begin
            @(posedge clk); #1;
            m++;
            if (m == 5 && (busy !== 1'b1 || core_entry !== 4'd6)) begin
                checks++;
                $display("[TB] FAIL single_wait_hold: got busy=%b entry=%0d expected busy=1 entry=6", busy, core_entry);
            end
        end
        checks++;
        if (m !== 11) $display("[TB] FAIL single_result_latency: got %0d cycles expected 11", m);
        else passed++;
        checks++;
        if ({res_entry, res_data} !== {4'd6, 8'd20}) $display("[TB] FAIL single_result: got entry=%0d data=%0d expected entry=6 data=20", res_entry, res_data);
        else passed++;
        wait_obs(obs_rd + 1, ok);
        checks++;
        if (!ok) $display("[TB] FAIL single_handshake: got %0d results expected %0d", obs_n, obs_rd + 1);
        else passed++;
        for (int i = 0; i < 1; i++) begin
            res_t e;
            res_t o;
            e = '0;
            if (sb.size() != 0) e = sb.pop_front();
            o = obs_log[obs_rd];
            obs_rd++;
            checks++;
            if (o !== e) $display("[TB] FAIL single_scoreboard: got entry=%0d data=%0d tmo=%b expected entry=%0d data=%0d tmo=%b", o.entry, o.data, o.tmo, e.entry, e.data, e.tmo);
            else passed++;
        end
    endtask

    task automatic test_fill_order();
        int n;
        int s0;
        bit ok;
        res_ready = 1'b0;
        push_job(4'd9, 1'b0);
        wait_res_valid(n);
        checks++;
        if (!res_valid) $display("[TB] FAIL fill_blocker: got res_valid=%b expected 1", res_valid);
        else passed++;
        s0 = starts;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (req_ready !== 1'b1) $display("[TB] FAIL fill_ready[%0d]: got %b expected 1", i, req_ready);
            else passed++;
            req_valid = 1'b1;
            req_entry = 4'(i);
            sb.push_back({4'(i), model_result(4'(i)), 1'b0});
            @(posedge clk); #1;
        end
        checks++;
        if (req_ready !== 1'b0) $display("[TB] FAIL fill_full: got req_ready=%b expected 0", req_ready);
        else passed++;
        req_entry = 4'd15;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (starts !== s0) $display("[TB] FAIL fill_no_issue: got %0d starts expected %0d", starts, s0);
        else passed++;
        res_ready = 1'b1;
        wait_obs(obs_rd + 5, ok);
        checks++;
        if (!ok) $display("[TB] FAIL fill_drain: got %0d results expected %0d", obs_n, obs_rd + 5);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            res_t e;
            res_t o;
            e = '0;
            if (sb.size() != 0) e = sb.pop_front();
            o = obs_log[obs_rd];
            obs_rd++;
            checks++;
            if (o !== e) $display("[TB] FAIL fill_order[%0d]: got entry=%0d data=%0d tmo=%b expected entry=%0d data=%0d tmo=%b", i, o.entry, o.data, o.tmo, e.entry, e.data, e.tmo);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int            n;
        int            s0;
        bit            ok;
        bit            stable;
        logic [EW-1:0] e0;
        logic [RW-1:0] d0;
        res_ready = 1'b0;
        push_job(4'd7, 1'b0);
        push_job(4'd8, 1'b0);
        wait_res_valid(n);
        e0 = res_entry;
        d0 = res_data;
        s0 = starts;
        checks++;
        if ({e0, d0} !== {4'd7, model_result(4'd7)}) $display("[TB] FAIL bp_first: got entry=%0d data=%0d expected entry=7 data=%0d", e0, d0, model_result(4'd7));
        else passed++;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!res_valid || res_entry !== e0 || res_data !== d0) stable = 1'b0;
        end
        checks++;
        if (!stable) $display("[TB] FAIL bp_hold: got unstable result expected held entry=%0d data=%0d", e0, d0);
        else passed++;
        checks++;
        if (starts !== s0) $display("[TB] FAIL bp_no_start: got %0d starts expected %0d", starts, s0);
        else passed++;
        res_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({core_start, core_entry, res_valid} !== {1'b1, 4'd8, 1'b0}) $display("[TB] FAIL bp_release: got start=%b entry=%0d valid=%b expected start=1 entry=8 valid=0", core_start, core_entry, res_valid);
        else passed++;
        wait_obs(obs_rd + 2, ok);
        checks++;
        if (!ok) $display("[TB] FAIL bp_drain: got %0d results expected %0d", obs_n, obs_rd + 2);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            res_t e;
            res_t o;
            e = '0;
            if (sb.size() != 0) e = sb.pop_front();
            o = obs_log[obs_rd];
            obs_rd++;
            checks++;
            if (o !== e) $display("[TB] FAIL bp_order[%0d]: got entry=%0d data=%0d tmo=%b expected entry=%0d data=%0d tmo=%b", i, o.entry, o.data, o.tmo, e.entry, e.data, e.tmo);
            else passed++;
        end
    endtask

    task automatic test_spurious_done();
        int n0;
        bit seen;
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk); #1;
        end
        n0 = obs_n;
        seen = 1'b0;
        spurious_req = 1'b1;
        @(posedge clk); #1;
        spurious_req = 1'b0;
        repeat (6) begin
            if (res_valid || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) $display("[TB] FAIL spurious_done: got res_valid/busy activity expected none");
        else passed++;
        checks++;
        if (obs_n !== n0) $display("[TB] FAIL spurious_results: got %0d results expected %0d", obs_n, n0);
        else passed++;
    endtask

`ifdef JOB_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int m;
        bit ok;
        res_ready = 1'b1;
        core_hang = 1'b1;
        push_job(4'd3, 1'b1);
        for (int i = 0; i < 20 && !core_start; i++) begin
            @(posedge clk); #1;
        end
        core_hang = 1'b0;
        m = 0;
        while (!res_valid && m < 100) begin
            @(posedge clk); #1;
            m++;
        end
        checks++;
        if (m !== TMO + 1) $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", m, TMO + 1);
        else passed++;
        checks++;
        if ({res_timeout, res_data, res_entry} !== {1'b1, 8'd0, 4'd3}) $display("[TB] FAIL timeout_result: got tmo=%b data=%0d entry=%0d expected tmo=1 data=0 entry=3", res_timeout, res_data, res_entry);
        else passed++;
        push_job(4'd4, 1'b0);
        wait_obs(obs_rd + 2, ok);
        checks++;
        if (!ok) $display("[TB] FAIL timeout_drain: got %0d results expected %0d", obs_n, obs_rd + 2);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            res_t e;
            res_t o;
            e = '0;
            if (sb.size() != 0) e = sb.pop_front();
            o = obs_log[obs_rd];
            obs_rd++;
            checks++;
            if (o !== e) $display("[TB] FAIL timeout_order[%0d]: got entry=%0d data=%0d tmo=%b expected entry=%0d data=%0d tmo=%b", i, o.entry, o.data, o.tmo, e.entry, e.data, e.tmo);
            else passed++;
        end
    endtask
`endif

    task automatic test_mid_reset();
        logic [20:0] got;
        int          s0;
        int          n0;
        res_ready = 1'b1;
        push_job(4'd5, 1'b0);
        for (int i = 0; i < 20 && !core_start; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        got = {req_ready, core_start, core_entry, res_valid, res_entry, res_data, res_timeout, busy};
        checks++;
        if (got !== {1'b1, 20'h0}) $display("[TB] FAIL midreset_outputs: got %h expected %h", got, {1'b1, 20'h0});
        else passed++;
        sb.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        s0 = starts;
        n0 = obs_n;
        repeat (10) begin
            @(posedge clk); #1;
        end
        checks++;
        if (starts !== s0) $display("[TB] FAIL midreset_no_start: got %0d starts expected %0d", starts, s0);
        else passed++;
        checks++;
        if ({busy, req_ready, res_valid} !== 3'b010) $display("[TB] FAIL midreset_idle: got busy/ready/valid %b expected 010", {busy, req_ready, res_valid});
        else passed++;
        checks++;
        if (obs_n !== n0) $display("[TB] FAIL midreset_results: got %0d results expected %0d", obs_n, n0);
        else passed++;
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap_errs !== 0) $display("[TB] FAIL start_while_busy: got %0d overlapping starts expected 0", overlap_errs);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_order();
        test_backpressure();
        test_spurious_done();
`ifdef JOB_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_mid_reset();
        test_no_overlap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
